// File: rtl/dot_product_ctrl.sv
// Sequencer for one matrix-multiply output element C = sum_k A[k]*B[k]: memory fetch, ALU MUL/ADD, write-back.
// Optional build macro MAC_ZERO_SKIP_EN: a zero A operand skips the B fetch, MUL and ACC for that term.
module dot_product_ctrl #(
  parameter int DW = 16,
  parameter int AW = 12,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic [AW-1:0] base_a,
  input  logic [AW-1:0] base_b,
  input  logic [AW-1:0] stride_b,
  input  logic [AW-1:0] addr_c,
  output logic          busy,
  output logic          done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_out,
  output logic          ac_rst_en,
  output logic          ac_write_en,
  output logic          ac_inc_en,
  output logic          ac_alu_to_ac,
  input  logic [DW-1:0] ac_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_RD_A, S_WAIT_A, S_RD_B, S_WAIT_B,
    S_MUL, S_ACC, S_NEXT, S_STORE, S_DONE
  } state_t;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;

  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d, idx_q, idx_d;
  logic [AW-1:0] base_a_q, base_a_d, base_b_q, base_b_d;
  logic [AW-1:0] stride_q, stride_d, addr_c_q, addr_c_d;
  logic [AW-1:0] pa_q, pa_d, pb_q, pb_d;
  logic [DW-1:0] opa_q, opa_d, opb_q, opb_d, prod_q, prod_d;

  // Reserved accumulator controls, never used by this sequencer.
  assign ac_write_en = 1'b0;
  assign ac_inc_en   = 1'b0;
  assign busy        = (state_q != S_IDLE);

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    base_a_d     = base_a_q;
    base_b_d     = base_b_q;
    stride_d     = stride_q;
    addr_c_d     = addr_c_q;
    pa_d         = pa_q;
    pb_d         = pb_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    prod_d       = prod_q;
    done         = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    alu_op       = OP_PASS;
    alu_a        = '0;
    alu_b        = '0;
    ac_rst_en    = 1'b0;
    ac_alu_to_ac = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d    = len;
          base_a_d = base_a;
          base_b_d = base_b;
          stride_d = stride_b;
          addr_c_d = addr_c;
          state_d  = S_CLR;
        end
      end
      S_CLR: begin
        ac_rst_en = 1'b1;
        idx_d     = '0;
        pa_d      = base_a_q;
        pb_d      = base_b_q;
        state_d   = (len_q == '0) ? S_STORE : S_RD_A;
      end
      S_RD_A: begin
        mem_req  = 1'b1;
        mem_addr = pa_q;
        if (mem_gnt) state_d = S_WAIT_A;
      end
      S_WAIT_A: begin
        if (mem_rvalid) begin
          opa_d = mem_rdata;
`ifdef MAC_ZERO_SKIP_EN
          state_d = (mem_rdata == '0) ? S_NEXT : S_RD_B;
`else
          state_d = S_RD_B;
`endif
        end
      end
      S_RD_B: begin
        mem_req  = 1'b1;
        mem_addr = pb_q;
        if (mem_gnt) state_d = S_WAIT_B;
      end
      S_WAIT_B: begin
        if (mem_rvalid) begin
          opb_d   = mem_rdata;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        alu_op  = OP_MUL;
        alu_a   = opa_q;
        alu_b   = opb_q;
        prod_d  = alu_out;
        state_d = S_ACC;
      end
      S_ACC: begin
        alu_op       = OP_ADD;
        alu_a        = prod_q;
        alu_b        = ac_data;
        ac_alu_to_ac = 1'b1;
        state_d      = S_NEXT;
      end
      S_NEXT: begin
        idx_d   = idx_q + 1'b1;
        pa_d    = pa_q + 1'b1;
        pb_d    = pb_q + stride_q;
        state_d = ((idx_q + 1'b1) == len_q) ? S_STORE : S_RD_A;
      end
      S_STORE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_c_q;
        mem_wdata = ac_data;
        if (mem_gnt) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      idx_q    <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      stride_q <= '0;
      addr_c_q <= '0;
      pa_q     <= '0;
      pb_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      stride_q <= stride_d;
      addr_c_q <= addr_c_d;
      pa_q     <= pa_d;
      pb_q     <= pb_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      prod_q   <= prod_d;
    end
  end

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Bench for dot_product_ctrl: memory/ALU/accumulator environment plus a scoreboard monitor.
`timescale 1ns/1ps
module tb_dot_product_ctrl;
  localparam int DW = 16;
  localparam int AW = 12;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic [AW-1:0] base_a = '0, base_b = '0, stride_b = '0, addr_c = '0;
  logic          busy, done, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = 16'hDEAD;
  logic [1:0]    alu_op;
  logic [DW-1:0] alu_a, alu_b, alu_out, ac_data;
  logic          ac_rst_en, ac_write_en, ac_inc_en, ac_alu_to_ac;

  always #5 clk = ~clk;

  dot_product_ctrl #(.DW(DW), .AW(AW), .LW(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .base_a(base_a), .base_b(base_b),
    .stride_b(stride_b), .addr_c(addr_c), .busy(busy), .done(done), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .alu_op(alu_op), .alu_a(alu_a),
    .alu_b(alu_b), .alu_out(alu_out), .ac_rst_en(ac_rst_en), .ac_write_en(ac_write_en),
    .ac_inc_en(ac_inc_en), .ac_alu_to_ac(ac_alu_to_ac), .ac_data(ac_data)
  );

  // ALU and accumulator environment
  always_comb begin
    case (alu_op)
      2'b01:   alu_out = alu_a + alu_b;
      2'b10:   alu_out = alu_a * alu_b;
      default: alu_out = alu_a;
    endcase
  end

  logic [DW-1:0] ac_q = 16'h5A5A;
  always @(posedge clk) begin
    if (ac_rst_en) ac_q <= '0;
    else if (ac_alu_to_ac) ac_q <= alu_out;
  end
  assign ac_data = ac_q;

  int checks = 0;
  int errors = 0;
  int edges = 0;
  int t0 = 0;
  always @(posedge clk) edges <= edges + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;
  wr_t           wr_q[$];
  logic [AW-1:0] rd_q[$];
  int            done_q[$];

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int            gnt_dly = 0, rv_dly = 1, wcnt = 0, rv_cnt = 0;
  logic [DW-1:0] rv_data = '0;
  logic          prev_pend = 1'b0, prev_we = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_wdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder and scoreboard monitor share one process so gnt is decided before it is checked.
  always @(negedge clk) begin
    wr_t w;
    mem_rvalid = 1'b0;
    mem_gnt    = 1'b0;
    mem_rdata  = 16'hDEAD;
    if (rst) begin
      wcnt = 0;
      rv_cnt = 0;
      prev_pend = 1'b0;
    end else begin
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rv_data;
        end
      end
      if (prev_pend) begin
        chk("req_held", {31'd0, mem_req}, 32'd1);
        chk("addr_held", {20'd0, mem_addr}, {20'd0, prev_addr});
        chk("we_held", {31'd0, mem_we}, {31'd0, prev_we});
        if (prev_we) chk("wdata_held", {16'd0, mem_wdata}, {16'd0, prev_wdata});
      end
      if (mem_req) begin
        if (wcnt >= gnt_dly) begin
          mem_gnt = 1'b1;
          wcnt = 0;
          if (mem_we) begin
            if (wr_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_write: addr 0x%0h data 0x%0h expected none", mem_addr, mem_wdata);
            end else begin
              w = wr_q.pop_front();
              chk("wr_addr", {20'd0, mem_addr}, {20'd0, w.addr});
              chk("wr_data", {16'd0, mem_wdata}, {16'd0, w.data});
              if (w.cyc >= 0) chk("wr_cycle", edges - t0, w.cyc);
            end
            mem[mem_addr] = mem_wdata;
          end else begin
            if (rd_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_read: addr 0x%0h expected none", mem_addr);
            end else begin
              chk("rd_addr", {20'd0, mem_addr}, {20'd0, rd_q.pop_front()});
            end
            rv_data = mem[mem_addr];
            rv_cnt  = rv_dly;
          end
        end else begin
          wcnt++;
        end
      end
      prev_pend  = mem_req && !mem_gnt;
      prev_addr  = mem_addr;
      prev_we    = mem_we;
      prev_wdata = mem_wdata;
      chk("ac_ctrl_onehot",
          {29'd0, ac_write_en, ac_inc_en, (ac_rst_en & ac_alu_to_ac)}, 32'd0);
      if (done) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: cycle %0d expected none", edges - t0);
        end else begin
          int dc;
          dc = done_q.pop_front();
          if (dc >= 0) chk("done_cycle", edges - t0, dc);
        end
      end
    end
  end

  task automatic launch(input int n, input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                        input logic [AW-1:0] sb, input logic [AW-1:0] ca,
                        input logic [DW-1:0] expv, input int wr_cyc, input int dn_cyc);
    wr_t w;
    for (int k = 0; k < n; k++) begin
      rd_q.push_back(ba + AW'(k));
`ifdef MAC_ZERO_SKIP_EN
      if (mem[ba + AW'(k)] != '0)
`endif
      rd_q.push_back(bb + AW'(k) * sb);
    end
    w.addr = ca; w.data = expv; w.cyc = wr_cyc;
    wr_q.push_back(w);
    done_q.push_back(dn_cyc);
    @(negedge clk);
    start = 1'b1; len = LW'(n); base_a = ba; base_b = bb; stride_b = sb; addr_c = ca;
    @(negedge clk);
    t0 = edges - 1;
    start = 1'b0;
    // Inputs changed after acceptance must not affect the running element.
    len = 8'hFF; base_a = 12'hABC; base_b = 12'h123; stride_b = 12'h777; addr_c = 12'h555;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic finish_run(input logic [AW-1:0] ca, input logic [DW-1:0] expv);
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      start = ((edges - t0) == 4);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within 3000 cycles expected done pulse");
    end
    @(negedge clk);
    chk("mem_c", {16'd0, mem[ca]}, {16'd0, expv});
    chk("rd_q_drained", rd_q.size(), 0);
    chk("wr_q_drained", wr_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'hFFFF;
    mem[12'h010] = 16'd1; mem[12'h011] = 16'd2; mem[12'h012] = 16'd3;
    mem[12'h020] = 16'd4; mem[12'h021] = 16'd5; mem[12'h022] = 16'd6;
    mem[12'h100] = 16'd1; mem[12'h101] = 16'd1; mem[12'h102] = 16'd1;
    mem[12'hFFE] = 16'd3; mem[12'h002] = 16'd4; mem[12'h006] = 16'd5;
    mem[12'h040] = 16'h0100; mem[12'h050] = 16'h0100;
    mem[12'h060] = 16'd0; mem[12'h061] = 16'd2; mem[12'h062] = 16'd0;
    mem[12'h070] = 16'd7; mem[12'h071] = 16'd5; mem[12'h072] = 16'd9;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_req_we", {30'd0, mem_req, mem_we}, 32'd0);
    chk("rst_addr_wdata", {4'd0, mem_addr, mem_wdata}, 32'd0);
    chk("rst_alu", {14'd0, alu_op, alu_a}, 32'd0);
    chk("rst_alu_b", {16'd0, alu_b}, 32'd0);
    chk("rst_ac_ctrl", {28'd0, ac_rst_en, ac_write_en, ac_inc_en, ac_alu_to_ac}, 32'd0);
    rst = 1'b0;

    // Basic 3-term product, zero-wait memory: 1*4+2*5+3*6 = 32
    launch(3, 12'h010, 12'h020, 12'd1, 12'h030, 16'd32, 23, 24);
    finish_run(12'h030, 16'd32);

    // Empty product writes 0
    launch(0, 12'h010, 12'h020, 12'd1, 12'h031, 16'd0, 2, 3);
    finish_run(12'h031, 16'd0);

    // Slow memory: grant after 3 wait cycles, read data 2 cycles after grant
    gnt_dly = 3; rv_dly = 2;
    launch(3, 12'h010, 12'h020, 12'd1, 12'h032, 16'd32, -1, -1);
    finish_run(12'h032, 16'd32);
    gnt_dly = 0; rv_dly = 1;

    // B pointer wraps past the top of memory: 1*3+1*4+1*5 = 12
    launch(3, 12'h100, 12'hFFE, 12'd4, 12'h033, 16'd12, 23, 24);
    finish_run(12'h033, 16'd12);

    // Product truncated to DW bits: 0x100*0x100 -> 0
    launch(1, 12'h040, 12'h050, 12'd1, 12'h034, 16'd0, 9, 10);
    finish_run(12'h034, 16'd0);

    // Reset during WAIT_B of term 2 (cycle 12), then rerun
    launch(3, 12'h010, 12'h020, 12'd1, 12'h035, 16'd32, -1, -1);
    for (int i = 0; i < 100 && (edges - t0) < 12; i++) @(negedge clk);
    chk("abort_reached_cycle", edges - t0, 12);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_req", {31'd0, mem_req}, 32'd0);
    chk("abort_ac_ctrl", {28'd0, ac_rst_en, ac_write_en, ac_inc_en, ac_alu_to_ac}, 32'd0);
    rst = 1'b0;
    rd_q.delete(); wr_q.delete(); done_q.delete();
    chk("abort_no_write", {16'd0, mem[12'h035]}, 32'h0000FFFF);
    launch(3, 12'h010, 12'h020, 12'd1, 12'h035, 16'd32, 23, 24);
    finish_run(12'h035, 16'd32);

    // Zero A terms: 0*7+2*5+0*9 = 10
`ifdef MAC_ZERO_SKIP_EN
    launch(3, 12'h060, 12'h070, 12'd1, 12'h036, 16'd10, 15, 16);
`else
    launch(3, 12'h060, 12'h070, 12'd1, 12'h036, 16'd10, 23, 24);
`endif
    finish_run(12'h036, 16'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
